imem_prog_loader: RTL

// - Parametrised program loader for the MIPS instruction memory.
// - Accepts instruction words over a valid/ready stream and writes them into
//   the byte-wide imem one byte per cycle (order set by BIG_END).
// - Holds the core in stop (cpu_start=0) while loading, then releases it.
// - Replaces hard-wired bench assigns; the load is sequential and checked.

---
 rtl/imem_prog_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
// imem_prog_loader
// Loads a program into the byte-wide MIPS instruction memory from a word
// stream, one byte per cycle, and holds the core stopped until the load ends.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   load_req             pulse: start a new load, aborting any load or run
//   wr_valid/wr_ready    word stream handshake; wr_data is the word, wr_last
//                        marks the final word of the program
//   mem_we/mem_addr/     byte write port into the imem
//   mem_wdata
//   cpu_start            core run enable, high once the program is loaded
//   busy                 load in progress
//   word_cnt             words committed in the current or last load
//   err_ovf              sticky: a word was offered after DEPTH words filled
//   dbg_state            FSM state: 0 IDLE, 1 ACCEPT, 2 WRITE, 3 RUN
//
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is high exactly while the FSM is in ACCEPT and depends only on
// state, never on wr_valid. load_req in the same cycle wins and the word is
// dropped.
module imem_prog_loader #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 50,
  parameter int ADDR_W  = 8,
  parameter int BASE    = 0,
  parameter int BIG_END = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_req,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_last,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [7:0]                   mem_wdata,
  output logic                         cpu_start,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   word_cnt,
  output logic                         err_ovf,
  output logic [1:0]                   dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                full_q, full_d;   // RUN was entered by filling DEPTH
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Byte number i of a word in write order; BIG_END only flips which lane
  // goes first, addresses still increase.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
    logic [DATA_W-1:0] sh;
    int                sel;
    sel = (BIG_END != 0) ? (NB - 1 - int'(i)) : int'(i);
    sh  = w >> (8 * sel);
    return sh[7:0];
  endfunction

  // Wraps modulo 2**ADDR_W by construction of the ADDR_W-wide arithmetic.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [CNT_W-1:0] cnt,
                                                  input logic [IDX_W-1:0] i);
    return ADDR_W'(BASE) + ADDR_W'(cnt) * ADDR_W'(NB) + ADDR_W'(i);
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_d = start_q;
    err_d   = err_q;

    if (load_req) begin
      state_d = S_ACCEPT;
      cnt_d   = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
      start_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ACCEPT: begin
          // wr_ready is 1 here, so wr_valid alone means a handshake.
          if (wr_valid) begin
            word_d  = wr_data;
            last_d  = wr_last;
            idx_d   = '0;
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = byte_addr(cnt_q, '0);
            wdata_d = pick_byte(wr_data, '0);
          end
        end
        S_WRITE: begin
          if (idx_q == IDX_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_q || (cnt_q + CNT_W'(1)) == DEPTH_C) begin
              state_d = S_RUN;
              start_d = 1'b1;
              full_d  = !last_q;
            end else begin
              state_d = S_ACCEPT;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            we_d    = 1'b1;
            addr_d  = byte_addr(cnt_q, idx_q + IDX_W'(1));
            wdata_d = pick_byte(word_q, idx_q + IDX_W'(1));
          end
        end
        S_RUN: begin
          if (wr_valid && full_q) err_d = 1'b1;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_ACCEPT) || (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign wr_ready  = (state_q == S_ACCEPT);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_start = start_q;
  assign busy      = busy_q;
  assign word_cnt  = cnt_q;
  assign err_ovf   = err_q;
  assign dbg_state = state_q;

endmodule
